// File: rtl/mux_arbiter_2.sv
// mux_arbiter_2: two-requester burst arbiter driving a shared 2:1 data mux
// into a single registered output stage.
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_req0/1       requester n holds a request / has a beat available
//   i_last0/1      current beat of requester n ends its burst
//   i_data0/1      beat data of requester n
//   i_out_ready    downstream accepts o_out_data this cycle
//   o_gnt0/1       requester n owns the shared path (one-hot or zero)
//   o_sel          data mux select, 0 = i_data0, 1 = i_data1
//   o_out_valid    o_out_data holds a valid beat
//   o_out_data     registered beat from the owning requester
//
// Contains the shared 2:1 mux sub-module followed by the arbiter top.

module mux_2to1 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_zero,
    input  logic [WIDTH-1:0] i_one,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_out
);

    assign o_out = i_sel ? i_one : i_zero;

endmodule

module mux_arbiter_2 #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0,
    input  logic             i_req1,
    input  logic             i_last0,
    input  logic             i_last1,
    input  logic [WIDTH-1:0] i_data0,
    input  logic [WIDTH-1:0] i_data1,
    input  logic             i_out_ready,
    output logic             o_gnt0,
    output logic             o_gnt1,
    output logic             o_sel,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_out_data
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } state_t;

    // Count of the beat that closes a maximum-length burst.
    localparam logic [7:0] CntLast = 8'(MAX_BURST - 1);

    state_t           r_state;
    logic             r_prio;
    logic [7:0]       r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic             w_owner;      // index of the current owner when owning
    logic             w_owning;
    logic             w_own_req;
    logic             w_own_last;
    logic             w_other_req;
    logic             w_ld;
    logic             w_accept;
    logic             w_release;
    logic [WIDTH-1:0] w_mux;

    // Grants and select are pure state decodes.
    assign o_gnt0      = (r_state == StOwn0);
    assign o_gnt1      = (r_state == StOwn1);
    assign o_sel       = (r_state == StOwn1);
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

    assign w_owner     = (r_state == StOwn1);
    assign w_owning    = (r_state == StOwn0) || (r_state == StOwn1);
    assign w_own_req   = w_owner ? i_req1  : i_req0;
    assign w_own_last  = w_owner ? i_last1 : i_last0;
    assign w_other_req = w_owner ? i_req0  : i_req1;

    // Output stage can load when empty or when its beat is being taken.
    assign w_ld        = !r_out_valid || i_out_ready;
    assign w_accept    = w_owning && w_own_req && w_ld;
    assign w_release   = w_accept && (w_own_last || (r_cnt == CntLast));

    mux_2to1 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .i_zero (i_data0),
        .i_one  (i_data1),
        .i_sel  (o_sel),
        .o_out  (w_mux)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_prio      <= 1'b0;
            r_cnt       <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_ld) begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out_data <= w_mux;
                end
            end

            case (r_state)
                StIdle: begin
                    if (i_req0 && i_req1) begin
                        r_state <= r_prio ? StOwn1 : StOwn0;
                    end else if (i_req0) begin
                        r_state <= StOwn0;
                    end else if (i_req1) begin
                        r_state <= StOwn1;
                    end
                end
                StOwn0, StOwn1: begin
                    if (!w_own_req) begin
                        // Owner withdrew: abort without taking a beat.
                        r_state <= StIdle;
                        r_cnt   <= 8'd0;
                        r_prio  <= !w_owner;
                    end else if (w_release) begin
                        r_cnt  <= 8'd0;
                        r_prio <= !w_owner;
                        // Hand straight to a waiting peer, no idle bubble.
                        if (w_other_req) begin
                            r_state <= w_owner ? StOwn0 : StOwn1;
                        end else begin
                            r_state <= StIdle;
                        end
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arbiter_2.sv
// Self-checking bench for mux_arbiter_2 (WIDTH=8, MAX_BURST=4): directed
// scenarios followed by random traffic, all compared against a
// transaction-level reference model.

module tb_mux_arbiter_2;

    localparam int MaxBurst = 4;

    logic       clk;
    logic       rst_n;
    logic       req0, req1, last0, last1, out_ready;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, sel, out_valid;
    logic [7:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner (-1 = nobody), beats taken in this grant,
    // tie-break preference and the contents of the output stage.
    int         m_owner;
    int         m_beats;
    int         m_prio;
    logic       m_valid;
    logic [7:0] m_data;

    mux_arbiter_2 #(
        .WIDTH     (8),
        .MAX_BURST (MaxBurst)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req0      (req0),
        .i_req1      (req1),
        .i_last0     (last0),
        .i_last1     (last1),
        .i_data0     (data0),
        .i_data1     (data1),
        .i_out_ready (out_ready),
        .o_gnt0      (gnt0),
        .o_gnt1      (gnt1),
        .o_sel       (sel),
        .o_out_valid (out_valid),
        .o_out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, ".gnt0"}, int'(gnt0), int'(m_owner == 0));
        check_eq({tag, ".gnt1"}, int'(gnt1), int'(m_owner == 1));
        check_eq({tag, ".sel"},  int'(sel),  int'(m_owner == 1));
        check_eq({tag, ".valid"}, int'(out_valid), int'(m_valid));
        check_eq({tag, ".data"}, int'(out_data), int'(m_data));
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_prio  = 0;
        m_valid = 1'b0;
        m_data  = 8'h00;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit         rq [2];
        bit         lst[2];
        logic [7:0] dat[2];
        bit         room;
        int         o;
        rq[0] = req0;   rq[1] = req1;
        lst[0] = last0; lst[1] = last1;
        dat[0] = data0; dat[1] = data1;
        room = !m_valid || out_ready;
        if (m_owner < 0) begin
            if (room) m_valid = 1'b0;
            if (rq[0] && rq[1]) m_owner = m_prio;
            else if (rq[0])     m_owner = 0;
            else if (rq[1])     m_owner = 1;
        end else begin
            o = m_owner;
            if (!rq[o]) begin
                if (room) m_valid = 1'b0;
                m_owner = -1;
                m_beats = 0;
                m_prio  = 1 - o;
            end else if (room) begin
                m_data  = dat[o];
                m_valid = 1'b1;
                m_beats = m_beats + 1;
                if (lst[o] || m_beats == MaxBurst) begin
                    m_beats = 0;
                    m_prio  = 1 - o;
                    m_owner = rq[1-o] ? 1 - o : -1;
                end
            end
        end
    endtask

    // Called at a falling edge: drive, clock once, check after the edge,
    // return at the next falling edge.
    task automatic cycle(input bit r0, input bit r1, input bit l0, input bit l1,
                         input logic [7:0] d0, input logic [7:0] d1, input bit rdy,
                         input string tag);
        req0 = r0; req1 = r1; last0 = l0; last1 = l1;
        data0 = d0; data1 = d1; out_ready = rdy;
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
        @(negedge clk);
    endtask

    // Called at a falling edge; asserts reset between edges.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model(tag);
        req0 = 0; req1 = 0; last0 = 0; last1 = 0;
        data0 = 8'h00; data1 = 8'h00; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] held;

    initial begin
        rst_n = 1'b0;
        req0 = 0; req1 = 0; last0 = 0; last1 = 0;
        data0 = 8'h00; data1 = 8'h00; out_ready = 1'b0;
        model_reset();
        #1;
        check_model("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Single beat from idle.
        cycle(1, 0, 1, 0, 8'hA5, 8'h00, 1, "single.e1");
        check_eq("single.gnt0_e1", int'(gnt0), 1);
        cycle(1, 0, 1, 0, 8'hA5, 8'h00, 1, "single.e2");
        check_eq("single.data", int'(out_data), 'hA5);
        check_eq("single.idle", int'(gnt0 | gnt1), 0);
        cycle(0, 0, 0, 0, 8'h00, 8'h00, 1, "single.e3");

        // Tie with requester 0 preferred, two beats then direct handoff.
        apply_reset("tie.rst");
        cycle(1, 1, 0, 0, 8'h11, 8'h99, 1, "tie.grant");
        check_eq("tie.gnt0", int'(gnt0), 1);
        cycle(1, 1, 0, 0, 8'h11, 8'h99, 1, "tie.b1");
        cycle(1, 1, 1, 0, 8'h22, 8'h99, 1, "tie.b2");
        check_eq("tie.handoff_gnt1", int'(gnt1), 1);
        check_eq("tie.handoff_sel", int'(sel), 1);
        check_eq("tie.b2_data", int'(out_data), 'h22);
        cycle(0, 1, 0, 1, 8'h00, 8'h77, 1, "tie.r1");
        check_eq("tie.r1_data", int'(out_data), 'h77);
        cycle(1, 1, 0, 0, 8'h00, 8'h00, 1, "tie.again");
        check_eq("tie.prio_back0", int'(gnt0), 1);
        cycle(0, 0, 0, 0, 8'h00, 8'h00, 1, "tie.drop");

        // Burst cap at MaxBurst beats.
        apply_reset("cap.rst");
        cycle(1, 1, 0, 0, 8'h00, 8'hEE, 1, "cap.grant");
        for (int i = 1; i <= MaxBurst; i++) begin
            cycle(1, 1, 0, 0, 8'(8'h40 + i), 8'hEE, 1, "cap.beat");
            check_eq("cap.data", int'(out_data), 'h40 + i);
            check_eq("cap.gnt1", int'(gnt1), int'(i == MaxBurst));
        end

        // Backpressure holds data, count and grant.
        apply_reset("bp.rst");
        cycle(1, 0, 0, 0, 8'h31, 8'h00, 1, "bp.grant");
        cycle(1, 0, 0, 0, 8'h31, 8'h00, 1, "bp.b1");
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 0, 8'h50 + 8'(i), 8'hCC, 0, "bp.stall");
            check_eq("bp.hold_data", int'(out_data), int'(held));
            check_eq("bp.hold_gnt0", int'(gnt0), 1);
        end
        // Three more beats still fit in the burst after the stall.
        cycle(1, 1, 0, 0, 8'h32, 8'hCC, 1, "bp.b2");
        check_eq("bp.resume", int'(out_data), 'h32);
        cycle(1, 1, 0, 0, 8'h33, 8'hCC, 1, "bp.b3");
        cycle(1, 1, 0, 0, 8'h34, 8'hCC, 1, "bp.b4");
        check_eq("bp.cap_gnt1", int'(gnt1), 1);

        // Abort after one beat, then requester 1 wins the next tie.
        apply_reset("abort.rst");
        cycle(1, 0, 0, 0, 8'h61, 8'h00, 1, "abort.grant");
        cycle(1, 0, 0, 0, 8'h61, 8'h00, 1, "abort.b1");
        cycle(0, 0, 0, 0, 8'h62, 8'h00, 1, "abort.drop");
        check_eq("abort.idle", int'(gnt0 | gnt1), 0);
        check_eq("abort.no_beat", int'(out_valid), 0);
        cycle(1, 1, 0, 0, 8'h00, 8'h00, 1, "abort.tie");
        check_eq("abort.tie_gnt1", int'(gnt1), 1);

        // Reset in the middle of a requester-1 burst.
        apply_reset("mid.rst0");
        cycle(0, 1, 0, 0, 8'h00, 8'h5A, 1, "mid.grant");
        cycle(0, 1, 0, 0, 8'h00, 8'h5A, 0, "mid.b1");
        check_eq("mid.pre_valid", int'(out_valid), 1);
        #2;
        apply_reset("mid.rst");
        check_eq("mid.data_zero", int'(out_data), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  8'($urandom), 8'($urandom), $urandom_range(0, 2) != 0, "rand");
            if (i % 700 == 699) begin
                apply_reset("rand.rst");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_arbiter_2.md
MUX_ARBITER_2 -- requirements
Module: mux_arbiter_2

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, which sets the data width of both requester data inputs and OUT_DATA.
REQ-002 The module SHALL have parameter MAX_BURST, default 4, which sets the maximum number of beats per grant (legal range 1..255).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 REQ0, REQ1  input  1 each  requester n holds request / has beat available.
REQ-006 LAST0, LAST1  input  1 each  current beat of requester n is final beat of its burst.
REQ-007 DATA0, DATA1  input  WIDTH each  beat data of requester n.
REQ-008 OUT_READY  input  1  downstream accepts OUT_DATA this cycle.
REQ-009 GNT0, GNT1  output  1 each  requester n owns shared path; one-hot or zero.
REQ-010 SEL  output  1  select for the shared 2:1 data mux; 0 = DATA0, 1 = DATA1.
REQ-011 OUT_VALID  output  1  OUT_DATA holds a valid beat.
REQ-012 OUT_DATA  output  WIDTH  registered beat from the owning requester.

Function
REQ-013 The FSM SHALL have states IDLE, OWN0 and OWN1; GNT0 = (state==OWN0), GNT1 = (state==OWN1), SEL = (state==OWN1); all three are decoded from state only.
REQ-014 The data path SHALL be one instance of the team 2:1 mux (ZERO=DATA0, ONE=DATA1, SEL), feeding the output register.
REQ-015 Output register load enable: LD = !OUT_VALID | OUT_READY.
REQ-016 Beat accepted when GNTn & REQn & LD; on accept OUT_DATA <= mux output and OUT_VALID <= 1.
REQ-017 When LD=1 and no beat is accepted, OUT_VALID SHALL go to 0; when LD=0, OUT_DATA and OUT_VALID SHALL hold.
REQ-018 Latency: a beat accepted at edge k appears on OUT_DATA/OUT_VALID after edge k; grant asserts one cycle after a request is seen in IDLE.
REQ-019 Priority bit PRIO (0 = requester 0 wins a tie) SHALL select the winner when REQ0 & REQ1 in IDLE.
REQ-020 IDLE transitions: both requesting -> OWN(PRIO); only REQ0 -> OWN0; only REQ1 -> OWN1; neither -> IDLE; no beat is accepted in IDLE.
REQ-021 Beat counter CNT (8 bits) SHALL increment on each accepted beat while owning.
REQ-022 Release SHALL occur in OWNn when a beat is accepted with LASTn=1 or CNT==MAX_BURST-1.
REQ-023 On release: CNT <= 0 and PRIO <= other requester; next state = OWN(other) if the other REQ=1 that cycle (no idle bubble), else IDLE.
REQ-024 Abort: in OWNn with REQn=0, next state = IDLE, CNT <= 0, PRIO <= other, and no beat is accepted.
REQ-025 In OWNn with REQn=1 and LD=0, the module SHALL stay in OWNn with CNT unchanged (backpressure never releases the grant).
REQ-026 The non-owner's REQ, LAST and DATA SHALL have no effect except at the release/abort decision.

Reset
REQ-027 RST_N=0 SHALL immediately force state=IDLE, PRIO=0, CNT=0, OUT_VALID=0 and OUT_DATA=0, so that GNT0=GNT1=0 and SEL=0, including mid-burst.
REQ-028 After RST_N deasserts, the first rising edge SHALL behave per REQ-020.

Verification (WIDTH=8, MAX_BURST=4)
REQ-029 Reset mid-burst: in OWN1 with OUT_VALID=1, pull RST_N low between edges -> GNT1=0, SEL=0, OUT_VALID=0, OUT_DATA=0x00 without a clock edge.
REQ-030 Single beat: REQ0=1, LAST0=1, DATA0=0xA5, OUT_READY=1 from IDLE -> GNT0=1 after edge 1; OUT_DATA=0xA5 and OUT_VALID=1 after edge 2; state IDLE.
REQ-031 Tie and handoff: REQ0=REQ1=1 after reset, LAST0=1 on 2nd beat -> GNT0 for 2 beats, then GNT1=1 and SEL=1 on the next cycle, with no IDLE cycle; PRIO=1 then 0.
REQ-032 Burst cap: REQ0=1, LAST0=0 held, REQ1=1 -> exactly 4 beats of DATA0 accepted, then GNT1.
REQ-033 Backpressure: OUT_VALID=1 with OUT_READY=0 for 3 cycles -> OUT_DATA stable, CNT unchanged, grant held; transfer resumes on OUT_READY=1.
REQ-034 Abort: owner REQ0 drops after 1 beat with REQ1=0 -> IDLE next cycle; on a later tie, requester 1 is granted first.
